// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns the EX-stage taken/not-taken decision into a
// held redirect request for fetch, wrong-path flushes, misalignment flags and stats.
module branch_redirect_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             EX_VALID,
  input  logic [2:0]       EX_BRANCH_JUMP,
  input  logic             PC_SEL,
  input  logic [31:0]      EX_TARGET,
  input  logic             STALL,
  input  logic             IF_READY,
  output logic             REDIRECT_VALID,
  output logic [31:0]      REDIRECT_PC,
  output logic             FLUSH_IFID,
  output logic             FLUSH_IDEX,
  output logic             BUSY,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] BRANCH_COUNT,
  output logic [CNT_W-1:0] TAKEN_COUNT
);

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_t;

  localparam logic [2:0]       CODE_NONE = 3'b010;
  localparam logic [2:0]       CODE_JUMP = 3'b011;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t state;
  logic   qualify;
  logic   is_cond;
  logic   aligned;

  // Jumps redirect like branches but are left out of the branch statistics.
  assign qualify = EX_VALID && !STALL && (EX_BRANCH_JUMP != CODE_NONE);
  assign is_cond = (EX_BRANCH_JUMP != CODE_NONE) && (EX_BRANCH_JUMP != CODE_JUMP);
  assign aligned = (EX_TARGET[1:0] == 2'b00);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= IDLE;
      REDIRECT_VALID <= 1'b0;
      REDIRECT_PC    <= 32'h0;
      FLUSH_IFID     <= 1'b0;
      FLUSH_IDEX     <= 1'b0;
      BUSY           <= 1'b0;
      MISALIGN       <= 1'b0;
      BRANCH_COUNT   <= '0;
      TAKEN_COUNT    <= '0;
    end else begin
      MISALIGN <= 1'b0;
      case (state)
        IDLE: begin
          REDIRECT_VALID <= 1'b0;
          FLUSH_IFID     <= 1'b0;
          FLUSH_IDEX     <= 1'b0;
          BUSY           <= 1'b0;
          if (qualify) begin
            if (is_cond && (BRANCH_COUNT != CNT_MAX))
              BRANCH_COUNT <= BRANCH_COUNT + CNT_ONE;
            if (is_cond && PC_SEL && (TAKEN_COUNT != CNT_MAX))
              TAKEN_COUNT <= TAKEN_COUNT + CNT_ONE;
            // A misaligned target traps instead of redirecting, so nothing is flushed.
            if (PC_SEL && aligned) begin
              state          <= REDIRECT;
              REDIRECT_VALID <= 1'b1;
              REDIRECT_PC    <= EX_TARGET;
              FLUSH_IFID     <= 1'b1;
              FLUSH_IDEX     <= 1'b1;
              BUSY           <= 1'b1;
            end else if (PC_SEL) begin
              MISALIGN <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          // ID/EX is squashed once; IF/ID keeps being squashed until fetch moves.
          FLUSH_IDEX <= 1'b0;
          if (IF_READY) begin
            state          <= IDLE;
            REDIRECT_VALID <= 1'b0;
            FLUSH_IFID     <= 1'b0;
            BUSY           <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          REDIRECT_VALID <= 1'b0;
          FLUSH_IFID     <= 1'b0;
          FLUSH_IDEX     <= 1'b0;
          BUSY           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequential controller that consumes the EX-stage branch decision (the `PC_SEL` result of the branch comparison unit) and performs the resulting control-flow redirect. On a taken branch or jump it:
- latches the target,
- squashes the wrong-path instructions in IF/ID and ID/EX,
- holds a redirect request to the fetch stage until fetch accepts it.

It also flags misaligned targets and keeps saturating branch statistics. It sits between the EX stage and the PC/fetch logic of the RV32IM pipeline.

## Interface
Parameters:
- `CNT_W`, default 16: width of the statistics counters.

Ports:
- `CLK`  in  1  pipeline clock; all state updates on the rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `EX_VALID`  in  1  EX stage holds a valid instruction.
- `EX_BRANCH_JUMP`  in  3  branch/jump code of the EX instruction:
  - 000 BEQ, 001 BNE, 010 none, 011 JAL/JALR,
  - 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- `PC_SEL`  in  1  branch unit result; 1 = take target.
- `EX_TARGET`  in  32  computed branch/jump target.
- `STALL`  in  1  pipeline stall from the hazard/memory unit; EX is frozen.
- `IF_READY`  in  1  fetch accepts a redirect this cycle.
- `REDIRECT_VALID`  out  1  redirect request to fetch.
- `REDIRECT_PC`  out  32  redirect address.
- `FLUSH_IFID`  out  1  squash the IF/ID register.
- `FLUSH_IDEX`  out  1  squash the ID/EX register.
- `BUSY`  out  1  controller is redirecting; the hazard unit must freeze PC increment.
- `MISALIGN`  out  1  one-cycle pulse: taken target with `EX_TARGET[1:0] != 0`.
- `BRANCH_COUNT`  out  `CNT_W`  conditional branches evaluated.
- `TAKEN_COUNT`  out  `CNT_W`  conditional branches taken.

## Operation
- Qualifying event, sampled in IDLE: `EX_VALID & !STALL & EX_BRANCH_JUMP != 010`.
  - Conditional branch = any code except 010 and 011.
  - Taken = `PC_SEL == 1`.
- States:
  - **IDLE**: no redirect outstanding.
  - **REDIRECT**: request outstanding.
- IDLE → REDIRECT: on a qualifying event with `PC_SEL = 1` and `EX_TARGET[1:0] == 00`.
  - Latch `EX_TARGET` into `REDIRECT_PC`.
- Misaligned target: on a qualifying event with `PC_SEL = 1` and `EX_TARGET[1:0] != 00`.
  - Stay in IDLE.
  - Pulse `MISALIGN` for one cycle.
  - No redirect and no flush.
- REDIRECT → IDLE: when `IF_READY = 1` is sampled at a rising edge.
- In REDIRECT:
  - All EX inputs are ignored. ID/EX has been flushed, so `EX_VALID` is don't-care.
  - `STALL` does not affect the handshake.
- Counters:
  - `BRANCH_COUNT` increments on every qualifying conditional event.
  - `TAKEN_COUNT` increments when that event is also taken, including misaligned-taken.
  - Both saturate at all-ones. No wrap.
  - Jumps (011) are not counted.
- A not-taken branch or `STALL = 1` produces no control outputs.

## Timing
- Reset, asynchronous, while `RESET_N = 0`:
  - state = IDLE.
  - `REDIRECT_VALID`, `FLUSH_IFID`, `FLUSH_IDEX`, `BUSY`, `MISALIGN` = 0.
  - `REDIRECT_PC` = 0.
  - Counters = 0.
  - Reset asserted during REDIRECT abandons the request immediately.
- All outputs are registered. Latency from the qualifying edge is 1 cycle:
  - event sampled at edge N → outputs valid after edge N (cycle N+1).
- Cycle N+1, first REDIRECT cycle: `REDIRECT_VALID = 1`, `BUSY = 1`, `FLUSH_IFID = 1`, `FLUSH_IDEX = 1`.
- Later REDIRECT cycles: `FLUSH_IFID = 1`, `FLUSH_IDEX = 0`.
  - `REDIRECT_VALID` and `REDIRECT_PC` are held stable.
- Handshake completes at the edge where `REDIRECT_VALID & IF_READY`.
  - All four redirect outputs read 0 in the following cycle.
  - A new qualifying event may be sampled at that same following edge.
- `IF_READY` already high at entry: REDIRECT lasts exactly one cycle.
- `MISALIGN` is high for exactly the cycle after the event.
- Counter values reflect an event one cycle after its edge.

## Test plan
- **Reset state**: hold `RESET_N = 0` mid-REDIRECT → all outputs 0 asynchronously; after release, state IDLE.
- **BEQ taken**: `EX_BRANCH_JUMP = 000`, `PC_SEL = 1`, `EX_TARGET = 0x0000_0100`, `IF_READY = 1` → one cycle of `REDIRECT_VALID`, `FLUSH_IFID`, `FLUSH_IDEX` with `REDIRECT_PC = 0x100`; `BRANCH_COUNT = 1`, `TAKEN_COUNT = 1`.
- **Delayed acceptance**: JAL (011), target `0x2000`, `IF_READY` low for 3 cycles → `REDIRECT_VALID` and `BUSY` high for 4 cycles, `FLUSH_IDEX` only in the first cycle, `FLUSH_IFID` in all 4, counters unchanged; a BNE presented during the wait is ignored.
- **Not-taken and stalled**:
  - BGE with `PC_SEL = 0` → no flush, `BRANCH_COUNT + 1`, `TAKEN_COUNT` unchanged.
  - Same event with `STALL = 1` → no change at all.
- **Misaligned target**: BLTU taken, `EX_TARGET = 0x0000_0102` → `MISALIGN` pulse of 1 cycle, no redirect, `TAKEN_COUNT + 1`.
- **Saturation and back-to-back**:
  - Preload via 65535 taken BEQs, then one more → both counters stay `0xFFFF`.
  - Two taken branches separated by one idle cycle → two distinct redirects.
